// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 five-stage pipeline.
package riscv_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: valid/pc/instr with flush > hold > load priority.
module if_id_register import riscv_pkg::*; #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (hold_i) begin
      valid_q <= valid_q;
      pc_q    <= pc_q;
      instr_q <= instr_q;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// fills the IF/ID register, honouring hazard stalls and EX redirects.
module if_stage import riscv_pkg::*; #(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     buf_instr_q, buf_instr_d;

  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_load_pc;
  logic [31:0]     ifid_load_instr;

  // Gated by reset_n so no request escapes while the stage is held in reset.
  assign imem_req_valid = reset_n && (state_q == FETCH) && !redirect_valid;
  assign imem_addr      = pc_q;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_pc_d        = req_pc_q;
    drop_d          = drop_q;
    buf_pc_d        = buf_pc_q;
    buf_instr_d     = buf_instr_q;
    ifid_load       = 1'b0;
    ifid_load_pc    = req_pc_q;
    ifid_load_instr = imem_rsp_data;

    if (redirect_valid) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      buf_pc_d    = '0;
      buf_instr_d = NOP_INSTR;
      case (state_q)
        WAIT: begin
          // The single outstanding response is either consumed now or dropped later.
          if (imem_rsp_valid) begin
            state_d = FETCH;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_req_valid && imem_req_ready) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = FETCH;
            end else if (!stall) begin
              ifid_load = 1'b1;
              state_d   = FETCH;
            end else begin
              buf_pc_d    = req_pc_q;
              buf_instr_d = imem_rsp_data;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load       = 1'b1;
            ifid_load_pc    = buf_pc_q;
            ifid_load_instr = buf_instr_q;
            state_d         = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // An unstalled cycle with nothing new to load inserts a bubble.
  assign ifid_flush = redirect_valid || (!stall && !ifid_load);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      buf_pc_q    <= '0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  if_id_register #(
    .XLEN(XLEN)
  ) u_if_id_register (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (ifid_flush),
    .hold_i  (stall),
    .load_i  (ifid_load),
    .pc_i    (ifid_load_pc),
    .instr_i (ifid_load_instr),
    .valid_o (if_id_valid),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small latency-programmable imem model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;

  int errors = 0;
  int checks = 0;
  int lat    = 1;

  always #5 clk = ~clk;

  if_stage #(
    .XLEN     (64),
    .RESET_PC (64'h1000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h1008) return 32'h00A00093;
    return a[31:0] ^ 32'h5A5A5A5A;
  endfunction

  // Memory: answers lat cycles after acceptance, reset together with the DUT.
  logic        mem_busy;
  logic [63:0] mem_a;
  int          mem_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_busy <= 1'b0;
      mem_a    <= '0;
      mem_cnt  <= 0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_busy <= 1'b1;
      mem_a    <= imem_addr;
      mem_cnt  <= lat;
    end else if (mem_busy) begin
      if (mem_cnt <= 1) mem_busy <= 1'b0;
      else mem_cnt <= mem_cnt - 1;
    end
  end

  assign imem_rsp_valid = mem_busy && (mem_cnt == 1);
  assign imem_rsp_data  = mem_word(mem_a);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic er, input logic [63:0] ea,
                         input logic ev, input logic [63:0] ep, input logic [31:0] ei);
    chk({tag, " req_valid"}, 64'(imem_req_valid), 64'(er));
    if (er) chk({tag, " imem_addr"}, imem_addr, ea);
    chk({tag, " if_id_valid"}, 64'(if_id_valid), 64'(ev));
    chk({tag, " if_id_pc"}, if_id_pc, ep);
    chk({tag, " if_id_instr"}, 64'(if_id_instr), 64'(ei));
  endtask

  // Drive one cycle's inputs, check settled outputs, advance past the next edge.
  task automatic cyc(input string tag, input logic st, input logic rv, input logic [63:0] rpc,
                     input logic rdy, input logic er, input logic [63:0] ea,
                     input logic ev, input logic [63:0] ep, input logic [31:0] ei);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    #1;
    chk_out(tag, er, ea, ev, ep, ei);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic        er;
    logic [63:0] ea;
    logic        ev;
    logic [63:0] ep;
    logic [31:0] ei;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait stream, then a 3-cycle stall over the 0x1008 response.
    tbl[0]  = '{1'b0, 1'b1, 64'h1000, 1'b0, 64'h0,    NOP};
    tbl[1]  = '{1'b0, 1'b0, 64'h1004, 1'b0, 64'h0,    NOP};
    tbl[2]  = '{1'b0, 1'b1, 64'h1004, 1'b1, 64'h1000, mem_word(64'h1000)};
    tbl[3]  = '{1'b0, 1'b0, 64'h1008, 1'b0, 64'h0,    NOP};
    tbl[4]  = '{1'b1, 1'b1, 64'h1008, 1'b1, 64'h1004, mem_word(64'h1004)};
    tbl[5]  = '{1'b1, 1'b0, 64'h100C, 1'b1, 64'h1004, mem_word(64'h1004)};
    tbl[6]  = '{1'b1, 1'b0, 64'h100C, 1'b1, 64'h1004, mem_word(64'h1004)};
    tbl[7]  = '{1'b0, 1'b0, 64'h100C, 1'b1, 64'h1004, mem_word(64'h1004)};
    tbl[8]  = '{1'b0, 1'b1, 64'h100C, 1'b1, 64'h1008, 32'h00A00093};
    tbl[9]  = '{1'b0, 1'b0, 64'h1010, 1'b0, 64'h0,    NOP};
    tbl[10] = '{1'b0, 1'b1, 64'h1010, 1'b1, 64'h100C, mem_word(64'h100C)};

    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 64'h0, 1'b0, 64'h0, NOP);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cyc($sformatf("stream c%0d", i), tbl[i].st, 1'b0, 64'h0, 1'b1,
          tbl[i].er, tbl[i].ea, tbl[i].ev, tbl[i].ep, tbl[i].ei);
    end

    // Redirect while waiting; late response must be dropped.
    cyc("redir c11", 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, NOP);
    lat = 2;
    cyc("redir c12", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h1014, 1'b1, 64'h1010,
        mem_word(64'h1010));
    cyc("redir c13", 1'b0, 1'b1, 64'h2002, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, NOP);
    cyc("redir c14", 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, NOP);
    lat = 1;
    cyc("redir c15", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h2000, 1'b0, 64'h0, NOP);
    cyc("redir c16", 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, NOP);

    // Redirect together with stall over a valid IF/ID entry.
    cyc("rdst c17", 1'b1, 1'b1, 64'h3000, 1'b1, 1'b0, 64'h0, 1'b1, 64'h2000,
        mem_word(64'h2000));

    // Memory not ready for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("nrdy c%0d", 18 + i), 1'b0, 1'b0, 64'h0, 1'b0,
          1'b1, 64'h3000, 1'b0, 64'h0, NOP);
    end
    cyc("nrdy c23", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h3000, 1'b0, 64'h0, NOP);
    cyc("nrdy c24", 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, NOP);

    // Wrap-around from the top of the address space.
    cyc("wrap c25", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 64'h0,
        1'b1, 64'h3000, mem_word(64'h3000));
    cyc("wrap c26", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
        1'b0, 64'h0, NOP);
    cyc("wrap c27", 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, NOP);
    cyc("wrap c28", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h0, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC));

    // Reset asserted mid-WAIT: fetch restarts cleanly at RESET_PC.
    reset_n = 1'b0;
    #1;
    chk_out("rst_wait", 1'b0, 64'h0, 1'b0, 64'h0, NOP);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("rst c0", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h1000, 1'b0, 64'h0, NOP);
    cyc("rst c1", 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, NOP);
    cyc("rst c2", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h1004, 1'b1, 64'h1000,
        mem_word(64'h1000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RV64 pipeline, directly upstream of instruction decode. It owns the program counter and issues one request at a time to instruction memory over a valid/ready handshake. It writes the IF/ID pipeline register that decode reads. The load-use hazard unit's stall holds the stage. A redirect from execute (taken branch, JAL, JALR) flushes the stage and restarts fetch at the new target.

## Interface
- `XLEN`, 64, PC and address width.
- `RESET_PC`, 64'h0, first fetch address after reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard-unit stall; hold IF/ID and buffered fetch.
- `redirect_valid`  in  1  control-transfer resolved in EX; flush and refetch.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] forced to 0.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  XLEN  fetch address (= pc while requesting).
- `imem_rsp_valid`  in  1  instruction word returned; exactly one per accepted request, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc`  out  XLEN  PC of IF/ID instruction.
- `if_id_instr`  out  32  IF/ID instruction; NOP 32'h00000013 when invalid.

## Operation
- Reset values: `pc`=RESET_PC, state FETCH, `drop`=0, `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=NOP, buffer cleared.
- `imem_req_valid` is 0 while `reset_n`=0.
- FETCH:
  - `imem_req_valid` = !redirect_valid.
  - On handshake: `req_pc`<=pc, `pc`<=pc+4 (mod 2^XLEN), go to WAIT.
- WAIT, on `imem_rsp_valid`:
  - if `drop`: discard, clear drop, go to FETCH.
  - else if !stall: load IF/ID {1, req_pc, data}, go to FETCH.
  - else: capture {req_pc, data} in buffer, go to HOLD.
- HOLD, when !stall: load IF/ID from buffer, go to FETCH.
- IF/ID update rule:
  - stall=1: hold.
  - stall=0 with no new instruction loaded this cycle: bubble (valid=0, pc=0, instr=NOP).
- Redirect has highest priority over stall and response:
  - `pc`<=redirect_pc & ~3.
  - IF/ID <- bubble; buffer discarded.
  - WAIT without a response this cycle: set `drop`, stay in WAIT.
  - WAIT with a response this cycle: discard it, go to FETCH.
  - FETCH or HOLD: go to FETCH.
  - No request is issued in the redirect cycle.
- A second redirect while `drop` is set: update `pc` only; `drop` stays 1 (still exactly one outstanding response).
- At most one outstanding request; no request issued in WAIT or HOLD.

## Timing
- Zero-wait memory (ready=1, rsp one cycle after accept):
  - request in cycle n, response in n+1, IF/ID visible in n+2.
  - Throughput: one instruction per 2 cycles.
- `imem_req_valid` and `imem_addr` are combinational from state, `pc` and `redirect_valid`; all other outputs are registered.
- Stall asserted for k cycles with a response pending: instruction reaches IF/ID in the first cycle after stall drops. No loss, no duplication.
- Reset asserted mid-WAIT: state returns to FETCH and `drop` clears. The memory must also be reset, so no stale response arrives.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `NOP_INSTR` = 32'h00000013, fetch-state enum {FETCH, WAIT, HOLD}.
- One sub-module `if_id_register`: valid/pc/instr with load, hold and flush controls. Flush takes priority over hold, hold over load. Async active-low reset.

## Test plan
- Reset release, RESET_PC=0x1000, ready=1, 1-cycle memory, stall=0 -> addresses 0x1000, 0x1004, 0x1008. Each reaches `if_id_pc` two cycles after its request; valid pulses every other cycle.
- Stall=1 for 3 cycles while WAIT response arrives (instr 0x00A00093) -> IF/ID holds the previous instruction. 0x00A00093 appears with valid=1 in the cycle after stall drops, exactly once.
- Redirect to 0x2002 while WAIT, response one cycle later -> response discarded, IF/ID bubble (NOP, valid=0), next request address 0x2000.
- Redirect and stall asserted in the same cycle with a valid IF/ID instruction -> IF/ID becomes bubble, `pc`=target, fetch resumes.
- `imem_req_ready` held 0 for 5 cycles -> `imem_req_valid`=1 and `imem_addr` stable throughout; `pc` does not advance.
- `pc`=0xFFFFFFFFFFFFFFFC fetched -> next request address 0x0 (wrap-around).
